// File: rtl/cmd_assembler.sv
// cmd_assembler
// Pairs UART bytes into 16-bit commands (high byte first) for the opcode
// decoder. A half-command that waits too long for its low byte is discarded.
// Each finished command carries its opcode field and a pre-computed opcode
// class, so the decoder can pick a handler without decoding it again.
//
// TIMEOUT_CYC must be >= 2. It is the number of cycles allowed between
// accepting the high byte and accepting the low byte.

module cmd_assembler #(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic [2:0]  opcode,
    output logic [1:0]  cmd_class,
    output logic        overrun,
    output logic        timeout_err
);

    // The counter only has to reach TIMEOUT_CYC-1, and it is cleared there.
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t         state_reg;
    logic [7:0]     hi_reg;
    logic [CW-1:0]  cnt_reg;
    logic [15:0]    cmd_reg;
    logic [2:0]     opcode_reg;
    logic [1:0]     class_reg;
    logic           cmd_rdy_reg;
    logic           overrun_reg;
    logic           timeout_err_reg;

    // Wildcard opcode class. The order of the tests sets the priority:
    // 0?? -> 1, 10? -> 2, 111 -> 3, and 110 is reserved (0).
    function automatic logic [1:0] classify(input logic [2:0] op);
        logic [1:0] cls;
        casez (op)
            3'b0??:  cls = 2'd1;
            3'b10?:  cls = 2'd2;
            3'b111:  cls = 2'd3;
            default: cls = 2'd0;
        endcase
        return cls;
    endfunction

    // Every offered byte is acknowledged at once, including bytes that get
    // dropped. Nothing is acknowledged while reset is held.
    assign clr_rx_rdy = rx_rdy & ~rst;

    assign cmd         = cmd_reg;
    assign opcode      = opcode_reg;
    assign cmd_class   = class_reg;
    assign cmd_rdy     = cmd_rdy_reg;
    assign overrun     = overrun_reg;
    assign timeout_err = timeout_err_reg;

    // Assembly FSM. It registers the command, opcode and class together, and
    // it produces the single-cycle overrun and timeout_err pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            hi_reg          <= '0;
            cnt_reg         <= '0;
            cmd_reg         <= '0;
            opcode_reg      <= '0;
            class_reg       <= '0;
            cmd_rdy_reg     <= 1'b0;
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            // The pulses last exactly one cycle unless a branch below sets them.
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (rx_rdy) begin
                        hi_reg    <= rx_byte;
                        cnt_reg   <= '0;
                        state_reg <= HIGH;
                    end
                end

                HIGH: begin
                    // A low byte arriving in the terminal cycle beats the timeout.
                    if (rx_rdy) begin
                        cmd_reg     <= {hi_reg, rx_byte};
                        opcode_reg  <= hi_reg[7:5];
                        class_reg   <= classify(hi_reg[7:5]);
                        cmd_rdy_reg <= 1'b1;
                        state_reg   <= FULL;
                    end else if (cnt_reg == CNT_TERM) begin
                        timeout_err_reg <= 1'b1;
                        cnt_reg         <= '0;
                        state_reg       <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                FULL: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy_reg <= 1'b0;
                        // The same edge that frees the slot can take the next
                        // high byte, so this case is not an overrun.
                        if (rx_rdy) begin
                            hi_reg    <= rx_byte;
                            cnt_reg   <= '0;
                            state_reg <= HIGH;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (rx_rdy) begin
                        // No room for the byte. Drop it and leave the command intact.
                        overrun_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_assembler.sv
// Testbench for cmd_assembler. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge. Expected commands go into a
// scoreboard queue when stimulus is driven. A monitor pops and compares
// them when cmd_rdy rises.

module tb_cmd_assembler;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [2:0]  opcode;
    logic [1:0]  cmd_class;
    logic        overrun;
    logic        timeout_err;

    typedef struct packed {
        logic [15:0] cmd;
        logic [2:0]  op;
        logic [1:0]  cls;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int ov_cnt   = 0;
    int to_cnt   = 0;
    int n_pushed = 0;
    int n_seen   = 0;
    logic prev_cmd_rdy = 1'b0;

    cmd_assembler #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .opcode      (opcode),
        .cmd_class   (cmd_class),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference classification, worked out from the opcode bit patterns.
    function automatic logic [1:0] ref_class(input logic [2:0] op);
        if (op[2] == 1'b0)           return 2'd1;
        else if (op[1] == 1'b0)      return 2'd2;
        else if (op[0] == 1'b1)      return 2'd3;
        else                         return 2'd0;
    endfunction

    function automatic exp_t make_exp(input logic [7:0] hi, input logic [7:0] lo);
        exp_t e;
        e.cmd = {hi, lo};
        e.op  = hi[7:5];
        e.cls = ref_class(hi[7:5]);
        return e;
    endfunction

    // Monitor: scoreboard compare on each new command, plus pulse counting.
    always @(negedge clk) begin
        if (!rst) begin
            if (overrun)     ov_cnt++;
            if (timeout_err) to_cnt++;
            if (cmd_rdy === 1'b1 && prev_cmd_rdy !== 1'b1) begin
                n_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 32'(cmd), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("cmd", 32'(cmd), 32'(e.cmd));
                    check("opcode", 32'(opcode), 32'(e.op));
                    check("cmd_class", 32'(cmd_class), 32'(e.cls));
                end
            end
        end
        prev_cmd_rdy = cmd_rdy;
    end

    // Offer a byte for one cycle. It must be acknowledged at once.
    task automatic send_byte(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_byte = b;
        #1;
        check("clr_rx_rdy", 32'(clr_rx_rdy), 32'd1);
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    // Send a high/low pair with 'gap' idle cycles between the two bytes.
    task automatic assemble(input logic [7:0] hi, input logic [7:0] lo, input int gap);
        exp_q.push_back(make_exp(hi, lo));
        n_pushed++;
        send_byte(hi);
        repeat (gap) @(negedge clk);
        send_byte(lo);
        check("cmd_rdy_set", 32'(cmd_rdy), 32'd1);
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_clr", 32'(cmd_rdy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        int to_before;
        logic [7:0] sweep [4];
        sweep[0] = 8'h20; sweep[1] = 8'h80; sweep[2] = 8'hE0; sweep[3] = 8'hC0;

        // Reset with a byte on offer.
        rst = 1'b1; rx_rdy = 1'b1; rx_byte = 8'h55; clr_cmd_rdy = 1'b0;
        #1;
        check("rst_clr_rx", 32'(clr_rx_rdy), 32'd0);
        repeat (2) @(negedge clk);
        check("rst_clr_rx2", 32'(clr_rx_rdy), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_class", 32'(cmd_class), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0; rx_rdy = 1'b0;
        @(negedge clk);

        // Normal command with back-to-back bytes. It holds until cleared, and the data stays after.
        assemble(8'hA5, 8'h3C, 0);
        repeat (3) @(negedge clk);
        check("cmd_rdy_hold", 32'(cmd_rdy), 32'd1);
        clear_cmd();
        check("cmd_kept", 32'(cmd), 32'hA53C);
        check("class_kept", 32'(cmd_class), 32'd2);

        // Class sweep.
        for (int i = 0; i < 4; i++) begin
            assemble(sweep[i], 8'(i + 1), i);
            clear_cmd();
        end

        // Timeout: the pulse appears in the cycle after edge N+TO.
        send_byte(8'h12);
        check("to_early", 32'(timeout_err), 32'd0);
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0) check("to_premature", 32'(timeout_err), 32'd0);
        end
        @(negedge clk);
        check("to_pulse", 32'(timeout_err), 32'd1);
        @(negedge clk);
        check("to_width", 32'(timeout_err), 32'd0);
        check("to_no_cmd", 32'(cmd_rdy), 32'd0);
        assemble(8'h40, 8'h01, 0);
        clear_cmd();

        // Low byte in the terminal cycle is accepted, and no timeout occurs.
        to_before = to_cnt;
        assemble(8'h12, 8'h34, TO - 1);
        @(negedge clk);
        check("term_no_to", 32'(to_cnt), 32'(to_before));
        clear_cmd();

        // Overrun: the byte is acknowledged and dropped, and the command is unchanged.
        assemble(8'h6B, 8'hCD, 1);
        held = cmd;
        send_byte(8'h77);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_cmd", 32'(cmd), 32'(held));
        check("ovr_cmd_rdy", 32'(cmd_rdy), 32'd1);
        @(negedge clk);
        check("ovr_width", 32'(overrun), 32'd0);
        clear_cmd();

        // Clear and a new high byte in the same cycle: no overrun.
        assemble(8'h30, 8'h31, 0);
        exp_q.push_back(make_exp(8'hE1, 8'h02));
        n_pushed++;
        clr_cmd_rdy = 1'b1;
        rx_rdy = 1'b1; rx_byte = 8'hE1;
        #1;
        check("sim_clr_rx", 32'(clr_rx_rdy), 32'd1);
        @(negedge clk);
        clr_cmd_rdy = 1'b0; rx_rdy = 1'b0;
        check("sim_no_ovr", 32'(overrun), 32'd0);
        check("sim_rdy_clr", 32'(cmd_rdy), 32'd0);
        send_byte(8'h02);
        check("sim_rdy", 32'(cmd_rdy), 32'd1);
        clear_cmd();

        // Reset while in HIGH, then a clean command.
        send_byte(8'h99);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rsth_cmd", 32'(cmd), 32'd0);
        check("rsth_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        check("rsth_stay", 32'(cmd_rdy), 32'd0);
        assemble(8'h55, 8'hAA, 2);
        clear_cmd();

        repeat (2) @(negedge clk);
        check("ovr_total", 32'(ov_cnt), 32'd1);
        check("to_total", 32'(to_cnt), 32'd1);
        check("cmds_seen", 32'(n_seen), 32'(n_pushed));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmd_assembler.md
# cmd_assembler

Byte-to-command assembly stage sitting directly upstream of the opcode decoder. Consumes the UART receiver's byte stream, pairs bytes into 16-bit commands (high byte first), and guards against stalled half-commands with an inter-byte timeout. It presents each command with its 3-bit opcode field and a pre-computed wildcard opcode class, which the decoder uses to select its handler.

## Interface
- `TIMEOUT_CYC`, default 5000: number of `clk` cycles allowed between the high and low byte. Must be ≥ 2.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx_byte`, input, 8: received byte. Valid while `rx_rdy` = 1.
- `rx_rdy`, input, 1: level held high by the UART until acknowledged.
- `clr_rx_rdy`, output, 1: one-cycle acknowledge. Combinational and asserted in the cycle a byte is taken.
- `cmd`, output, 16: assembled command, `{high, low}`.
- `cmd_rdy`, output, 1: command valid. Held high until cleared.
- `clr_cmd_rdy`, input, 1: downstream acknowledge of `cmd`.
- `opcode`, output, 3: equals `cmd[15:13]`. Registered together with `cmd`.
- `cmd_class`, output, 2: wildcard class of the opcode. Registered together with `cmd`.
- `overrun`, output, 1: one-cycle pulse when a byte is dropped.
- `timeout_err`, output, 1: one-cycle pulse when a half-command is discarded.

## Operation
- States: IDLE, HIGH, FULL.
- Reset (`rst` = 1) forces the following, overriding every other input that cycle:
  - state goes to IDLE;
  - `cmd`, `opcode`, `cmd_class`, `cmd_rdy`, `overrun`, `timeout_err` and the timeout counter all go to 0.
- `clr_rx_rdy` = `rx_rdy` & ~`rst` in every state. Every offered byte is acknowledged, including dropped ones.
- **IDLE**
  - `rx_rdy` = 1: latch `rx_byte` into the high-byte register, clear the counter, go to HIGH.
- **HIGH**
  - `rx_rdy` = 1: register the outputs and go to FULL.
    - `cmd` ← `{hi, rx_byte}`.
    - `opcode` ← `hi[7:5]`.
    - `cmd_class` ← classify(`hi[7:5]`).
  - Else, if counter = `TIMEOUT_CYC`−1: drop the high byte, pulse `timeout_err`, go to IDLE.
  - Else: increment the counter.
  - A byte arriving in the same cycle the count reaches terminal is accepted as the low byte. No timeout occurs.
- **FULL** (`cmd_rdy` = 1)
  - `clr_cmd_rdy` = 1 and `rx_rdy` = 0: clear `cmd_rdy`, go to IDLE.
  - `clr_cmd_rdy` = 1 and `rx_rdy` = 1 in the same cycle: clear `cmd_rdy` and latch the byte as the new high byte. Go to HIGH with the counter at 0. No overrun.
  - `clr_cmd_rdy` = 0 and `rx_rdy` = 1: drop the byte and pulse `overrun`. `cmd`, `opcode` and `cmd_class` are unchanged.
- `clr_cmd_rdy` is ignored in IDLE and HIGH.
- `cmd`, `opcode` and `cmd_class` hold their last values after `cmd_rdy` clears.
- classify(op), wildcard priority:
  - 3'b0?? → 2'd1
  - 3'b10? → 2'd2
  - 3'b111 → 2'd3
  - 3'b110 → 2'd0 (reserved/illegal)
- Counter width is $clog2(`TIMEOUT_CYC`). It never wraps, because it is reset on reaching the terminal value.

## Timing
- High byte: accepted on edge N. Low byte: offered at edge M ≥ N+1.
- `cmd_rdy`, `cmd`, `opcode` and `cmd_class` are all valid from edge M (registered). The decoder sees them one cycle after the low byte is acknowledged.
- Minimum byte-to-byte spacing is 1 cycle. Back-to-back `rx_rdy` pulses are fully consumed.
- Timeout: high byte accepted at edge N with no further bytes. `timeout_err` is high for the single cycle after edge N+`TIMEOUT_CYC`, and the state is IDLE from that edge.
- `overrun` and `timeout_err` are registered pulses, exactly one cycle wide.
- Reset mid-command (HIGH or FULL) discards all partial and complete data. `clr_rx_rdy` stays 0 during the `rst` cycle.

## Test plan
- **Reset:** `rst` for 2 cycles with `rx_rdy`=1 → all outputs 0, `clr_rx_rdy`=0, state IDLE.
- **Normal command:** bytes 0xA5 then 0x3C, 1 cycle apart → `cmd`=0xA53C, `opcode`=3'b101, `cmd_class`=2, `cmd_rdy` high until `clr_cmd_rdy`.
- **Class sweep:** high bytes 0x20, 0x80, 0xE0, 0xC0 → `cmd_class` = 1, 2, 3, 0.
- **Timeout:** with `TIMEOUT_CYC`=8, send 0x12 only → `timeout_err` pulses once 8 cycles later. A subsequent 0x40, 0x01 gives `cmd`=0x4001.
  - Repeat with the low byte landing exactly on the terminal cycle → command accepted, no `timeout_err`.
- **Overrun:** `cmd_rdy`=1 with no clear, send 0x77 → `overrun` pulse, `clr_rx_rdy` pulse, `cmd` unchanged.
- **Simultaneous events:** `clr_cmd_rdy` and byte 0xE1 in the same cycle, then 0x02 → no overrun, next `cmd`=0xE102, `cmd_class`=3.
  - Separately, assert `rst` in HIGH → next command assembles cleanly.
